// File: rtl/inst_encoder.sv
// Symbolic MIPS instruction encoder: packs kind/field requests into 32-bit
// words, queues them in a 2-entry FIFO tagged with sequential word addresses,
// and writes them out to instruction memory.
module inst_encoder #(
  parameter int          ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_kind,
  input  logic [4:0]        req_rs,
  input  logic [4:0]        req_rt,
  input  logic [4:0]        req_rd,
  input  logic [15:0]       req_imm,
  input  logic [25:0]       req_target,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              err_illegal,
  output logic [7:0]        illegal_cnt,
  output logic              addr_wrap
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  logic [31:0]       enc_word;
  logic              legal;
  logic [1:0]        count;
  logic [31:0]       data0, data1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [ADDR_W-1:0] ptr;
  logic              run;
  logic              accept, push, bad, pop;

  // Combinational encoder; kinds 14-15 leave legal low.
  always_comb begin
    enc_word = '0;
    legal    = 1'b1;
    case (req_kind)
      4'd0:  enc_word = {6'b000000, req_rs, req_rt, req_rd, 5'b0, 6'b100100};
      4'd1:  enc_word = {6'b000000, req_rs, req_rt, req_rd, 5'b0, 6'b100101};
      4'd2:  enc_word = {6'b000000, req_rs, req_rt, req_rd, 5'b0, 6'b100000};
      4'd3:  enc_word = {6'b000000, req_rs, req_rt, req_rd, 5'b0, 6'b100010};
      4'd4:  enc_word = {6'b000000, req_rs, req_rt, req_rd, 5'b0, 6'b101010};
      4'd5:  enc_word = {6'b001100, req_rs, req_rt, req_imm};
      4'd6:  enc_word = {6'b001101, req_rs, req_rt, req_imm};
      4'd7:  enc_word = {6'b001110, req_rs, req_rt, req_imm};
      4'd8:  enc_word = {6'b001111, 5'b0, req_rt, req_imm};
      4'd9:  enc_word = {6'b001000, req_rs, req_rt, req_imm};
      4'd10: enc_word = {6'b100011, req_rs, req_rt, req_imm};
      4'd11: enc_word = {6'b101011, req_rs, req_rt, req_imm};
      4'd12: enc_word = {6'b000100, req_rs, req_rt, req_imm};
      4'd13: enc_word = {6'b000010, req_target};
      default: legal = 1'b0;
    endcase
  end

  // req_ready depends only on registered state and clr, never on wr_ready.
  assign req_ready = run && (count < 2'd2) && !clr;
  assign accept    = req_valid && req_ready;
  assign push      = accept && legal;
  assign bad       = accept && !legal;
  assign wr_valid  = (count != 2'd0);
  assign pop       = wr_valid && wr_ready;
  assign wr_data   = data0;
  assign wr_addr   = addr0;

  // Holds req_ready low until the first clock after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run <= 1'b0;
    else        run <= 1'b1;
  end

  // Two-slot FIFO; slot 0 is the head and drives the write port directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 2'd0;
      data0 <= '0;
      data1 <= '0;
      addr0 <= BASE;
      addr1 <= BASE;
    end else if (clr) begin
      count <= 2'd0;
    end else if (pop && count == 2'd2) begin
      data0 <= data1;
      addr0 <= addr1;
      count <= 2'd1;
    end else if (pop && push) begin
      data0 <= enc_word;
      addr0 <= ptr;
    end else if (pop) begin
      count <= count - 2'd1;
    end else if (push) begin
      if (count == 2'd0) begin
        data0 <= enc_word;
        addr0 <= ptr;
      end else begin
        data1 <= enc_word;
        addr1 <= ptr;
      end
      count <= count + 2'd1;
    end
  end

  // Address pointer and sticky error/wrap status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr         <= BASE;
      err_illegal <= 1'b0;
      illegal_cnt <= 8'd0;
      addr_wrap   <= 1'b0;
    end else if (clr) begin
      ptr         <= BASE;
      err_illegal <= 1'b0;
      illegal_cnt <= 8'd0;
      addr_wrap   <= 1'b0;
    end else begin
      if (push) begin
        ptr <= ptr + ADDR_W'(1);
        if (&ptr) addr_wrap <= 1'b1;
      end
      if (bad) begin
        err_illegal <= 1'b1;
        if (illegal_cnt != 8'hFF) illegal_cnt <= illegal_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Scoreboard bench for inst_encoder: expected words/addresses are queued on
// accept and compared as the DUT writes them out.
module tb_inst_encoder;

  logic        clk, rst_n, clr;
  logic        req_valid, req_ready;
  logic [3:0]  req_kind;
  logic [4:0]  req_rs, req_rt, req_rd;
  logic [15:0] req_imm;
  logic [25:0] req_target;
  logic        wr_valid, wr_ready;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic        err_illegal, addr_wrap;
  logic [7:0]  illegal_cnt;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] q_data[$];
  logic [7:0]  q_addr[$];
  logic [7:0]  exp_ptr;
  logic [31:0] mon_d;
  logic [7:0]  mon_a;

  inst_encoder #(.ADDR_W(8), .BASE_ADDR(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind),
    .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd),
    .req_imm(req_imm), .req_target(req_target),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .err_illegal(err_illegal), .illegal_cnt(illegal_cnt), .addr_wrap(addr_wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write-port monitor: every completed write must match the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && wr_valid && wr_ready) begin
      checks++;
      if (q_data.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write got %08h@%0d required none", wr_data, wr_addr);
      end else begin
        mon_d = q_data.pop_front();
        mon_a = q_addr.pop_front();
        if (wr_data !== mon_d || wr_addr !== mon_a) begin
          errors++;
          $display("FAIL write got %08h@%0d required %08h@%0d", wr_data, wr_addr, mon_d, mon_a);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Offer one request and wait (bounded) for its accept; kinds 14-15 queue nothing.
  task automatic send(input logic [3:0] kind, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt,
                      input logic [31:0] exp_word);
    bit acc = 0;
    req_kind = kind; req_rs = rs; req_rt = rt; req_rd = rd;
    req_imm = imm; req_target = tgt; req_valid = 1'b1;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      if (req_ready === 1'b1) begin
        acc = 1;
        if (kind < 4'd14) begin
          q_data.push_back(exp_word);
          q_addr.push_back(exp_ptr);
          exp_ptr = exp_ptr + 8'd1;
        end
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    checks++;
    if (!acc) begin errors++; $display("FAIL send_timeout kind %0d got no accept required accept", kind); end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 100 && q_data.size() > 0; i++) @(posedge clk);
    @(posedge clk); #1;
    checks++;
    if (q_data.size() != 0 || wr_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_drain got pending %0d wr_valid %b required 0 0", name, q_data.size(), wr_valid);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; clr = 1'b0; req_valid = 1'b0; wr_ready = 1'b0;
    req_kind = '0; req_rs = '0; req_rt = '0; req_rd = '0; req_imm = '0; req_target = '0;
    exp_ptr = 8'd0;
    #12;
    checks++;
    if ({wr_valid, req_ready, err_illegal, addr_wrap} !== 4'b0 || wr_addr !== 8'd0 ||
        wr_data !== 32'd0 || illegal_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_values got v%b r%b e%b w%b a%0d d%08h c%0d required all zero",
               wr_valid, req_ready, err_illegal, addr_wrap, wr_addr, wr_data, illegal_cnt);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset got %b required 1", req_ready); end
  endtask

  task automatic test_basic;
    wr_ready = 1'b1;
    send(4'd9,  5'd1,  5'd2, 5'd0, 16'h0005, 26'd0, 32'h20220005);
    send(4'd10, 5'd29, 5'd8, 5'd0, 16'h0004, 26'd0, 32'h8FA80004);
    drain("basic");
  endtask

  task automatic test_mixed;
    wr_ready = 1'b1;
    send(4'd2,  5'd1, 5'd2,  5'd3,  16'hFFFF, 26'h3FFFFFF,  32'h00221820);
    send(4'd13, 5'd9, 5'd10, 5'd11, 16'hABCD, 26'h0000010, 32'h08000010);
    send(4'd8,  5'd7, 5'd4,  5'd9,  16'h1234, 26'h1555555, 32'h3C041234);
    send(4'd12, 5'd1, 5'd2,  5'd0,  16'hFFFF, 26'd0,       32'h1022FFFF);
    drain("mixed");
  endtask

  task automatic test_backpressure;
    logic [7:0] addr_a;
    wr_ready = 1'b0;
    addr_a = exp_ptr;
    send(4'd9, 5'd3, 5'd4, 5'd0, 16'h0011, 26'd0, 32'h20640011);
    send(4'd1, 5'd5, 5'd6, 5'd7, 16'h0000, 26'd0, 32'h00A63825);
    req_kind = 4'd3; req_rs = 5'd1; req_rt = 5'd2; req_rd = 5'd3; req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b0 || wr_valid !== 1'b1 || wr_data !== 32'h20640011 || wr_addr !== addr_a) begin
        errors++;
        $display("FAIL stall got r%b v%b %08h@%0d required r0 v1 20640011@%0d",
                 req_ready, wr_valid, wr_data, wr_addr, addr_a);
      end
    end
    @(posedge clk); #1;
    wr_ready = 1'b1;
    send(4'd3, 5'd1, 5'd2, 5'd3, 16'h0000, 26'd0, 32'h00221822);
    drain("backpressure");
  endtask

  task automatic test_illegal;
    wr_ready = 1'b1;
    send(4'd14, 5'd1, 5'd1, 5'd1, 16'h1111, 26'd0, 32'd0);
    checks++;
    if (err_illegal !== 1'b1 || illegal_cnt !== 8'd1) begin
      errors++;
      $display("FAIL illegal_first got e%b c%0d required e1 c1", err_illegal, illegal_cnt);
    end
    send(4'd6, 5'd0, 5'd5, 5'd0, 16'h00FF, 26'd0, 32'h340500FF);
    for (int i = 0; i < 300; i++) send(4'd14 + 4'(i % 2), 5'd0, 5'd0, 5'd0, 16'd0, 26'd0, 32'd0);
    checks++;
    if (err_illegal !== 1'b1 || illegal_cnt !== 8'd255) begin
      errors++;
      $display("FAIL illegal_saturate got e%b c%0d required e1 c255", err_illegal, illegal_cnt);
    end
    drain("illegal");
  endtask

  task automatic test_clr;
    wr_ready = 1'b0;
    send(4'd9, 5'd1, 5'd1, 5'd0, 16'h0AAA, 26'd0, 32'h20210AAA);
    send(4'd9, 5'd2, 5'd2, 5'd0, 16'h0BBB, 26'd0, 32'h20420BBB);
    clr = 1'b1;
    req_kind = 4'd9; req_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL clr_ready got %b required 0", req_ready); end
    @(posedge clk); #1;
    clr = 1'b0; req_valid = 1'b0;
    q_data.delete(); q_addr.delete(); exp_ptr = 8'd0;
    checks++;
    if (wr_valid !== 1'b0 || err_illegal !== 1'b0 || illegal_cnt !== 8'd0 || addr_wrap !== 1'b0) begin
      errors++;
      $display("FAIL clr_state got v%b e%b c%0d w%b required 0 0 0 0",
               wr_valid, err_illegal, illegal_cnt, addr_wrap);
    end
    wr_ready = 1'b1;
    send(4'd9, 5'd0, 5'd3, 5'd0, 16'h0042, 26'd0, 32'h20030042);
    drain("clr");
  endtask

  task automatic test_wrap;
    wr_ready = 1'b0;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    exp_ptr = 8'd0;
    wr_ready = 1'b1;
    for (int i = 0; i < 257; i++) begin
      send(4'd9, 5'd0, 5'd0, 5'd0, 16'(i), 26'd0, {16'h2000, 16'(i)});
      if (i == 254 || i == 255) begin
        checks++;
        if (addr_wrap !== (i == 255)) begin
          errors++;
          $display("FAIL addr_wrap after accept %0d got %b required %b", i + 1, addr_wrap, i == 255);
        end
      end
    end
    drain("wrap");
  endtask

  task automatic test_reset_mid;
    wr_ready = 1'b0;
    send(4'd0, 5'd4, 5'd5, 5'd6, 16'd0, 26'd0, 32'h00853024);
    send(4'd4, 5'd4, 5'd5, 5'd6, 16'd0, 26'd0, 32'h0085302A);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({wr_valid, req_ready, err_illegal, addr_wrap} !== 4'b0 || wr_addr !== 8'd0 ||
        wr_data !== 32'd0 || illegal_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_mid got v%b r%b e%b w%b a%0d d%08h c%0d required all zero",
               wr_valid, req_ready, err_illegal, addr_wrap, wr_addr, wr_data, illegal_cnt);
    end
    q_data.delete(); q_addr.delete(); exp_ptr = 8'd0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    wr_ready = 1'b1;
    send(4'd13, 5'd1, 5'd2, 5'd3, 16'd0, 26'h0000010, 32'h08000010);
    drain("reset_mid");
  endtask

  initial begin
    test_reset;
    test_basic;
    test_mixed;
    test_backpressure;
    test_illegal;
    test_clr;
    test_wrap;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_encoder.md
# inst_encoder

Sequential MIPS instruction encoder: accepts symbolic instruction requests (kind code plus register/immediate/target fields) over a valid/ready handshake and packs each one into a 32-bit MIPS word. It buffers encoded words in a 2-entry FIFO, tags each with a sequential word address, and writes them to instruction memory over a second valid/ready handshake. It is the producer side of the main decoder: bench program loaders and self-test generators use it to fill instruction memory that the datapath later fetches and decodes.

## Interface
- ADDR_W, 8, word-address width of instruction memory
- BASE_ADDR, 0, first word address after reset or clear
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  synchronous clear: empty FIFO, reload address, clear flags
- req_valid  in  1  request present
- req_ready  out  1  encoder can accept a request
- req_kind  in  4  instruction kind code
- req_rs / req_rt / req_rd  in  5 each  register fields
- req_imm  in  16  immediate
- req_target  in  26  jump target
- wr_valid  out  1  FIFO head valid
- wr_ready  in  1  memory accepts the write
- wr_addr  out  ADDR_W  word address of head
- wr_data  out  32  encoded word of head
- err_illegal  out  1  sticky: an illegal kind was received
- illegal_cnt  out  8  illegal requests, saturating at 255
- addr_wrap  out  1  sticky: address counter wrapped

## Operation
- Kind codes for R-type (op 000000, shamt 0, funct): 0 AND 100100, 1 OR 100101, 2 ADD 100000, 3 SUB 100010, 4 SLT 101010.
- I-type kind codes (opcode): 5 ANDI 001100, 6 ORI 001101, 7 XORI 001110, 8 LUI 001111, 9 ADDI 001000, 10 LW 100011, 11 SW 101011, 12 BEQ 000100.
- J-type kind code: 13 J 000010.
- Kinds 14-15 are illegal.
- R-type: {op, rs, rt, rd, 5'b0, funct}; req_imm and req_target are ignored.
- I-type: {op, rs, rt, imm}; for LUI the rs field is forced to 0; rd is ignored.
- J: {000010, target}; register fields are ignored.
- Accept occurs when req_valid && req_ready. On a legal accept the encoded word and the current address pointer are pushed into the FIFO, and the pointer increments.
- Illegal accept: nothing is pushed and the pointer is unchanged. err_illegal is set and illegal_cnt increments, saturating at 255.
- Pop occurs when wr_valid && wr_ready.
- Pointer at 2^ADDR_W-1 increments to 0 and sets addr_wrap.
- Push and pop in the same cycle are allowed when the FIFO count is 1. Count is unchanged in that case.
- req_ready = (count < 2) && !clr. There is no combinational path from wr_ready to req_ready.
- clr: FIFO is emptied (in-flight words are discarded), pointer is set to BASE_ADDR, and err_illegal, illegal_cnt and addr_wrap are cleared. A request presented in that cycle is not accepted.

## Timing
- Reset values (rst_n low, asynchronous): wr_valid 0, req_ready 0 while reset is held and 1 on the first cycle after release, wr_addr BASE_ADDR, wr_data 0, err_illegal 0, illegal_cnt 0, addr_wrap 0, pointer BASE_ADDR.
- Latency: a request accepted at edge N appears at the FIFO head with wr_valid high after edge N, if the FIFO was empty.
- Sustained throughput is 1 word/cycle when wr_ready is held high.
- wr_addr and wr_data are registered and stay stable while wr_valid && !wr_ready.
- Reset asserted mid-stream discards all FIFO contents immediately; no partial write is issued.
- Illegal and legal flags and the counter update on the accept edge.

## Test plan
- Write ADDI rs=1 rt=2 imm=0x0005 then LW rs=29 rt=8 imm=0x0004, wr_ready=1 → writes 0x20220005 @0, then 0x8FA80004 @1.
- Write ADD rs=1 rt=2 rd=3 (imm=0xFFFF, which must be ignored), J target=0x0000010, LUI rs=7 rt=4 imm=0x1234, BEQ rs=1 rt=2 imm=0xFFFF → 0x00221820, 0x08000010, 0x3C041234, 0x1022FFFF at consecutive addresses.
- Backpressure: hold wr_ready=0 and offer 3 requests → 2 accepted and req_ready drops. wr_data/wr_addr must stay stable; release wr_ready → both words drain in order.
- Kind 14, then ORI rs=0 rt=5 imm=0x00FF → err_illegal=1 and illegal_cnt=1; ORI 0x340500FF written at the address the illegal request would have used. Send 300 illegal requests → illegal_cnt=255.
- ADDR_W=2 with 5 legal requests → addresses 0,1,2,3,0; addr_wrap=1 after the fourth accept.
- Pulse clr with 2 words queued → wr_valid=0 the next cycle, flags cleared, next write at BASE_ADDR. Assert rst_n low mid-burst → outputs take their reset values asynchronously.
